// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared command/response types for the calculator port
//               responder and anything that models it.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    // Widths the pipeline stage struct is built with; the responder's
    // DATA_W/TAG_W parameters default to these and must match them.
    localparam int CALC_DATA_W = 32;
    localparam int CALC_TAG_W  = 2;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2
    } resp_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OP2  = 1'b1
    } state_e;

    // One entry of the response delay line.
    typedef struct packed {
        resp_e                  resp;
        logic [CALC_DATA_W-1:0] data;
        logic [CALC_TAG_W-1:0]  tag;
    } resp_t;

endpackage
`default_nettype wire

// File: rtl/calc_alu.sv
`default_nettype none
// ============================================================================
// Module      : calc_alu
// Description : Combinational calculator core. Maps a command and two
//               operands to a response code and result; any error forces
//               the result to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_alu
    import calc_pkg::*;
#(
    parameter int DATA_W = CALC_DATA_W
) (
    input  logic [3:0]        cmd,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic [1:0]        resp,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W:0] sum;

    // Evaluate the operation; default is the error response with zero data.
    always_comb begin
        sum  = {1'b0, op1} + {1'b0, op2};
        resp = RESP_ERR;
        data = '0;
        case (cmd)
            CMD_ADD: begin
                if (!sum[DATA_W]) begin
                    resp = RESP_OK;
                    data = sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                // Equal operands are a legal zero result, not an underflow.
                if (op2 <= op1) begin
                    resp = RESP_OK;
                    data = op1 - op2;
                end
            end
            CMD_SHL: begin
                resp = RESP_OK;
                data = op1 << op2[4:0];
            end
            CMD_SHR: begin
                resp = RESP_OK;
                data = op1 >> op2[4:0];
            end
            default: begin
                resp = RESP_ERR;
                data = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/calc_port_responder.sv
`default_nettype none
// ============================================================================
// Module      : calc_port_responder
// Description : DUT-side responder for one calculator request port. Takes a
//               two-cycle request (cmd+op1, then op2), computes the result and
//               returns a tagged one-cycle response LATENCY cycles after the
//               operand-2 cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_port_responder
    import calc_pkg::*;
#(
    parameter int DATA_W  = CALC_DATA_W,
    parameter int TAG_W   = CALC_TAG_W,
    parameter int LATENCY = 3             // 1..8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req_cmd,
    input  logic [DATA_W-1:0] req_data,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [1:0]        out_resp,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              proto_err
);

    state_e            state_q,     state_d;
    logic [3:0]        cmd_q,       cmd_d;
    logic [DATA_W-1:0] op1_q,       op1_d;
    logic [DATA_W-1:0] op2_q,       op2_d;
    logic [TAG_W-1:0]  tag_q,       tag_d;
    logic              issue_q,     issue_d;
    logic              proto_err_q, proto_err_d;

    // pipe_q[0] is loaded the edge after the operand-2 edge, so the last
    // stage (which drives the outputs directly) lands exactly LATENCY edges
    // after operand 2 was sampled.
    resp_t             pipe_q [LATENCY];
    resp_t             pipe_d [LATENCY];

    logic [1:0]        alu_resp;
    logic [DATA_W-1:0] alu_data;

    calc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .cmd  (cmd_q),
        .op1  (op1_q),
        .op2  (op2_q),
        .resp (alu_resp),
        .data (alu_data)
    );

    // Request FSM: capture cmd/op1/tag, then op2, then issue.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        tag_d       = tag_q;
        issue_d     = 1'b0;
        proto_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_cmd != CMD_NOP) begin
                    cmd_d   = req_cmd;
                    op1_d   = req_data;
                    tag_d   = req_tag;
                    state_d = ST_OP2;
                end
            end
            ST_OP2: begin
                // A command here is a protocol violation: it is dropped, but
                // the data word is still consumed as operand 2.
                op2_d       = req_data;
                issue_d     = 1'b1;
                proto_err_d = (req_cmd != CMD_NOP);
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Response delay line; empty stages carry all-zero entries so the
    // outputs are zero whenever no response is due.
    always_comb begin
        pipe_d[0] = '0;
        if (issue_q) begin
            pipe_d[0].resp = resp_e'(alu_resp);
            pipe_d[0].data = alu_data;
            pipe_d[0].tag  = tag_q;
        end
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // State, request latches and pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            tag_q       <= '0;
            issue_q     <= 1'b0;
            proto_err_q <= 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            tag_q       <= tag_d;
            issue_q     <= issue_d;
            proto_err_q <= proto_err_d;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign out_resp  = pipe_q[LATENCY-1].resp;
    assign out_data  = pipe_q[LATENCY-1].data;
    assign out_tag   = pipe_q[LATENCY-1].tag;
    assign proto_err = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_port_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_port_responder
// Description : Directed self-checking bench for calc_port_responder. A
//               negedge monitor matches every response against a queue of
//               hand-computed expectations, including the arrival cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_port_responder;
    import calc_pkg::*;

    localparam int LAT = 3;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [3:0]  req_cmd  = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_tag  = '0;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic [1:0]  out_tag;
    logic        proto_err;

    typedef struct {
        logic [1:0]  r;
        logic [31:0] d;
        logic [1:0]  t;
        int          c;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc          = 0;
    int   n_checks     = 0;
    int   n_fail       = 0;
    int   exp_perr_cyc = -1;
    bit   mon_en       = 1'b0;

    calc_port_responder #(
        .DATA_W  (32),
        .TAG_W   (2),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_cmd   (req_cmd),
        .req_data  (req_data),
        .req_tag   (req_tag),
        .out_resp  (out_resp),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    // Edge counter: after edge k (and until the next one) cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Response / proto_err monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            check("proto_err", 64'(proto_err), 64'(cyc == exp_perr_cyc));
            if (out_resp != 2'd0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 64'(out_resp), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp", 64'(out_resp), 64'(mon_e.r));
                    check("data", 64'(out_data), 64'(mon_e.d));
                    check("tag",  64'(out_tag),  64'(mon_e.t));
                    check("when", 64'(cyc),      64'(mon_e.c));
                end
            end else begin
                check("idle_zero", 64'({out_data, out_tag}), 64'd0);
            end
        end
    end

    // Drive one request. Entered just after a clock edge; returns just after
    // the edge that samples operand 2. c2 is driven on req_cmd in the
    // operand-2 cycle and the tag there is scrambled to prove it is ignored.
    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] tg, input logic [3:0] c2, input bit exp_en,
                        input logic [1:0] er, input logic [31:0] ed);
        exp_t e;
        req_cmd  = c;
        req_data = a;
        req_tag  = tg;
        @(posedge clk); #1;
        req_cmd  = c2;
        req_data = b;
        req_tag  = ~tg;
        @(posedge clk); #1;
        if (exp_en) begin
            e.r = er; e.d = ed; e.t = tg; e.c = cyc + LAT;
            exp_q.push_back(e);
        end
        if (c2 != 4'd0) exp_perr_cyc = cyc;
        req_cmd  = '0;
        req_data = '0;
        req_tag  = '0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 64'({out_resp, out_data, out_tag, proto_err}), 64'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Arithmetic / shift vectors
        send(CMD_ADD, 32'h0000_0005, 32'h0000_0007, 2'd2, 4'd0, 1'b1, RESP_OK,  32'h0000_000C);
        wait_drain();
        send(CMD_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 2'd0, 4'd0, 1'b1, RESP_ERR, 32'h0);
        send(CMD_SUB, 32'h0000_0003, 32'h0000_0005, 2'd1, 4'd0, 1'b1, RESP_ERR, 32'h0);
        send(CMD_SUB, 32'h0000_0009, 32'h0000_0009, 2'd3, 4'd0, 1'b1, RESP_OK,  32'h0);
        send(CMD_SHL, 32'h0000_0001, 32'h0000_0024, 2'd0, 4'd0, 1'b1, RESP_OK,  32'h0000_0010);
        send(CMD_SHR, 32'h8000_0000, 32'h0000_001F, 2'd1, 4'd0, 1'b1, RESP_OK,  32'h0000_0001);
        send(CMD_SHR, 32'h0000_00F0, 32'hFFFF_FFE4, 2'd2, 4'd0, 1'b1, RESP_OK,  32'h0000_000F);
        send(CMD_SUB, 32'h0000_0010, 32'h0000_0001, 2'd3, 4'd0, 1'b1, RESP_OK,  32'h0000_000F);
        send(4'd4,    32'h1234_5678, 32'h0000_0001, 2'd1, 4'd0, 1'b1, RESP_ERR, 32'h0);
        wait_drain();

        // Four back-to-back adds, tags 0..3
        send(CMD_ADD, 32'h0000_0100, 32'h0000_0001, 2'd0, 4'd0, 1'b1, RESP_OK, 32'h0000_0101);
        send(CMD_ADD, 32'h0000_0200, 32'h0000_0002, 2'd1, 4'd0, 1'b1, RESP_OK, 32'h0000_0202);
        send(CMD_ADD, 32'h0000_0300, 32'h0000_0003, 2'd2, 4'd0, 1'b1, RESP_OK, 32'h0000_0303);
        send(CMD_ADD, 32'h0000_0400, 32'h0000_0004, 2'd3, 4'd0, 1'b1, RESP_OK, 32'h0000_0404);
        wait_drain();

        // Command in the operand-2 cycle: dropped, operand still used
        send(CMD_ADD, 32'h0000_0020, 32'h0000_0022, 2'd2, CMD_ADD, 1'b1, RESP_OK, 32'h0000_0042);
        repeat (3) @(posedge clk); #1;
        send(CMD_ADD, 32'h0000_0001, 32'h0000_0001, 2'd3, 4'd0, 1'b1, RESP_OK, 32'h0000_0002);
        wait_drain();

        // Reset one cycle after the operand-2 cycle: request is lost
        send(CMD_ADD, 32'h0000_0011, 32'h0000_0022, 2'd1, 4'd0, 1'b0, RESP_NONE, 32'h0);
        rst_n = 1'b0;
        #1;
        check("rst_early_zero", 64'({out_resp, out_data, out_tag, proto_err}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk); #1;

        // Reset while the response sits on the outputs: cleared at once
        send(CMD_ADD, 32'h0000_0011, 32'h0000_0022, 2'd2, 4'd0, 1'b0, RESP_NONE, 32'h0);
        repeat (LAT) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_zero", 64'({out_resp, out_data, out_tag, proto_err}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk); #1;

        // Normal operation after reset
        send(CMD_ADD, 32'h0000_0030, 32'h0000_0003, 2'd2, 4'd0, 1'b1, RESP_OK, 32'h0000_0033);
        wait_drain();
        repeat (2) @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calc_port_responder.md
Name: calc_port_responder

Overview:
- Synthesizable responder for one calculator request/response port: the DUT-side end of the tb_if command protocol that the test bench drives.
- Captures a two-cycle request (command plus operand 1, then operand 2), computes the result and returns a tagged one-cycle response a fixed LATENCY later.
- Serves as the golden RTL stand-in behind wrapper for bench bring-up. Also instantiable as an in-loop reference model next to the real DUT.

Parameters:
- DATA_W, 32, operand and result width
- TAG_W, 2, request tag width
- LATENCY, 3, cycles from the operand-2 cycle to the response cycle; legal range 1..8

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_cmd  input  4  command; 0 = idle
- req_data  input  DATA_W  operand 1 in the command cycle, operand 2 in the following cycle
- req_tag  input  TAG_W  tag, sampled in the command cycle
- out_resp  output  2  0 none, 1 success, 2 overflow/underflow/invalid; nonzero for exactly 1 cycle
- out_data  output  DATA_W  result when out_resp = 1, else 0
- out_tag  output  TAG_W  tag of the request being answered
- proto_err  output  1  1-cycle pulse: nonzero req_cmd seen in an operand-2 cycle

Behaviour:
- Reset: asynchronous on rst_n low. All outputs go to 0, the FSM goes to IDLE and the pipeline is flushed. No response is ever emitted for a request in flight when reset asserts.
- Commands:
  - 1 add: unsigned, op1 + op2.
  - 2 sub: unsigned, op1 - op2.
  - 5 shl: op1 << op2[4:0].
  - 6 shr: logical, op1 >> op2[4:0].
  - All other nonzero codes (3, 4, 7..15) are invalid.
- FSM states: IDLE and OP2.
  - IDLE, req_cmd != 0: latch cmd, op1 (= req_data) and tag; go to OP2.
  - IDLE, req_cmd == 0: stay in IDLE.
  - OP2: latch op2 = req_data, issue the operation into the pipeline, return to IDLE.
  - OP2 with req_cmd != 0: that command is ignored and not queued. proto_err pulses the next cycle. The operand is still taken as op2.
- Result rules:
  - add with carry-out: resp 2, data 0.
  - sub with op2 > op1: resp 2, data 0.
  - sub with op2 == op1: resp 1, data 0.
  - Shifts never overflow; bits shifted out are discarded.
  - Invalid command: resp 2, data 0. It still consumes the operand-2 cycle.
- Timing:
  - Operand-2 sampled at edge T; out_resp, out_data and out_tag are valid in the cycle following edge T+LATENCY, for exactly 1 cycle.
  - Outputs are registered. out_resp returns to 0 the next cycle, and out_data/out_tag return to 0 whenever out_resp = 0.
- Throughput: at most one request per 2 cycles, so at most one issue per cycle and responses never collide. Pipeline depth is exactly LATENCY with no backpressure.
- Back-to-back: a new command in the cycle right after OP2 is accepted, giving response spacing of 2 cycles.
- Tags are echoed unchanged. Duplicate outstanding tags are legal and are answered in issue order.
- Widths: internal add uses DATA_W+1 bits to detect carry. Shift amount is always op2[4:0], regardless of the upper bits.

Decomposition:
- calc_pkg holds the shared types:
  - typedef enum logic [3:0] cmd_e: CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6.
  - typedef enum logic [1:0] resp_e: RESP_NONE, RESP_OK, RESP_ERR.
  - A packed struct resp_t of {resp, data, tag} for the pipeline stages.
- One sub-module, calc_alu: purely combinational; takes cmd, op1 and op2, produces resp and data.
- The FSM and the LATENCY-deep resp_t shift pipeline live in calc_port_responder. The bench reuses calc_pkg for its expected-value model.

Test Plan:
- Reset, then add 0x0000_0005 + 0x0000_0007 with tag 2 → at edge T+3: out_resp 1, out_data 0x0000_000C, out_tag 2; out_resp is 0 the following cycle.
- add 0xFFFF_FFFF + 0x1 → resp 2, data 0; sub 0x3 - 0x5 → resp 2, data 0; sub 0x9 - 0x9 → resp 1, data 0.
- shl 0x0000_0001 by 0x0000_0024 (amount 4) → 0x0000_0010; shr 0x8000_0000 by 31 → 0x0000_0001.
- Invalid command 4 with tag 1 → resp 2, data 0, tag 1 at LATENCY. Then 4 back-to-back adds with tags 0..3 → four responses, 2 cycles apart, in tag order.
- Command 1 in the OP2 cycle → proto_err high 1 cycle; only the first request is answered, and the next accepted command occurs only after IDLE.
- Issue an add, assert rst_n low 1 cycle after the operand-2 cycle → outputs 0 immediately, no response ever appears; the next request after release is answered normally.
